// File: rtl/ysyx_24100006_arb_pkg.sv
// Shared types and constants for the IFU/LSU read-channel arbiter.
package ysyx_24100006_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_AR   = 2'b01,
    S_R    = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IFU  = 2'b01,
    OWN_LSU  = 2'b10
  } arb_owner_e;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;

endpackage

// File: rtl/ysyx_24100006_arb_sel.sv
// Combinational winner select between the IFU and LSU read requests.
module ysyx_24100006_arb_sel (
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic prefer_ifu,
  output logic grant_ifu,
  output logic grant_lsu
);

  // LSU wins unless both request and the IFU is currently preferred
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (lsu_req && (!ifu_req || !prefer_ifu)) begin
      grant_lsu = 1'b1;
    end else if (ifu_req) begin
      grant_ifu = 1'b1;
    end else begin
      grant_ifu = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_24100006_axi_rd_arb.sv
// Two-master (IFU/LSU) single-outstanding AXI-Lite read arbiter.
// Define YSYX_ARB_RR_EN for round-robin tie-breaking; default is fixed LSU priority.
module ysyx_24100006_axi_rd_arb
  import ysyx_24100006_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [2:0]        out_arsize,
  output logic              out_arvalid,
  input  logic              out_arready,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic              out_rvalid,
  output logic              out_rready
);

  arb_state_e state_r;
  arb_owner_e owner_r;
  logic       idle_s;
  logic       prefer_ifu_s;
  logic       grant_ifu_s;
  logic       grant_lsu_s;

  assign idle_s = (state_r == S_IDLE);

`ifdef YSYX_ARB_RR_EN
  logic last_lsu_r;

  // Remembers whether the LSU took the previous grant so the IFU wins the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_lsu_r <= 1'b0;
    end else if (idle_s && (grant_ifu_s || grant_lsu_s)) begin
      last_lsu_r <= grant_lsu_s;
    end else begin
      last_lsu_r <= last_lsu_r;
    end
  end

  assign prefer_ifu_s = last_lsu_r;
`else
  assign prefer_ifu_s = 1'b0;
`endif

  ysyx_24100006_arb_sel u_sel (
    .ifu_req    (ifu_arvalid),
    .lsu_req    (lsu_arvalid),
    .prefer_ifu (prefer_ifu_s),
    .grant_ifu  (grant_ifu_s),
    .grant_lsu  (grant_lsu_s)
  );

  // arready pulses only in the idle cycle that latches the request
  assign ifu_arready = idle_s & grant_ifu_s;
  assign lsu_arready = idle_s & grant_lsu_s;

  // Grant / address / data-phase sequencing with registered downstream AR signals
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      owner_r     <= OWN_NONE;
      out_arvalid <= 1'b0;
      out_araddr  <= {ADDR_W{1'b0}};
      out_arsize  <= ARSIZE_WORD;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_lsu_s) begin
            out_araddr  <= lsu_araddr;
            out_arsize  <= lsu_arsize;
            out_arvalid <= 1'b1;
            owner_r     <= OWN_LSU;
            state_r     <= S_AR;
          end else if (grant_ifu_s) begin
            out_araddr  <= ifu_araddr;
            out_arsize  <= ARSIZE_WORD;
            out_arvalid <= 1'b1;
            owner_r     <= OWN_IFU;
            state_r     <= S_AR;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        S_AR: begin
          if (out_arready) begin
            out_arvalid <= 1'b0;
            state_r     <= S_R;
          end else begin
            state_r     <= S_AR;
          end
        end
        S_R: begin
          if (out_rvalid && out_rready) begin
            owner_r <= OWN_NONE;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_R;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          owner_r     <= OWN_NONE;
          out_arvalid <= 1'b0;
        end
      endcase
    end
  end

  // Route the read-data channel to the owner only while in the data phase
  always_comb begin
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    ifu_rdata  = {DATA_W{1'b0}};
    lsu_rdata  = {DATA_W{1'b0}};
    out_rready = 1'b0;
    if (state_r == S_R) begin
      case (owner_r)
        OWN_IFU: begin
          out_rready = ifu_rready;
          ifu_rvalid = out_rvalid;
          ifu_rdata  = out_rdata;
        end
        OWN_LSU: begin
          out_rready = lsu_rready;
          lsu_rvalid = out_rvalid;
          lsu_rdata  = out_rdata;
        end
        default: begin
          out_rready = 1'b0;
        end
      endcase
    end else begin
      out_rready = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_rd_arb.sv
// Randomized bench for the read arbiter, checked against a transaction-level model.
module tb_ysyx_24100006_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ifu_araddr, lsu_araddr, out_araddr, out_rdata;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic [2:0]  lsu_arsize, out_arsize;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic        out_arvalid, out_arready, out_rvalid, out_rready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_24100006_axi_rd_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .out_araddr(out_araddr), .out_arsize(out_arsize), .out_arvalid(out_arvalid),
    .out_arready(out_arready), .out_rdata(out_rdata), .out_rvalid(out_rvalid),
    .out_rready(out_rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus last-winner memory
  bit        m_busy, m_data_phase, m_who_lsu, m_last_lsu;
  bit [31:0] m_addr;
  bit [2:0]  m_size;
  // Masters' pending requests and the slave's pending read
  bit        ifu_pend, lsu_pend, sl_pend;
  bit [31:0] ifu_a, lsu_a, sl_addr;
  bit [2:0]  lsu_s;
  int        sl_cnt;
  bit        s_arhs, s_rhs, g_ifu, g_lsu, rst_now;
  int        n_collide = 0;

  task automatic model_reset();
    m_busy = 1'b0; m_data_phase = 1'b0; m_who_lsu = 1'b0; m_last_lsu = 1'b0;
    m_addr = 32'h0; m_size = 3'b010;
    ifu_pend = 1'b0; lsu_pend = 1'b0; sl_pend = 1'b0; sl_cnt = 0;
  endtask

  task automatic drive_inputs();
    if (!ifu_pend && ($urandom_range(0, 3) != 0)) begin
      ifu_pend = 1'b1;
      ifu_a = {$urandom_range(0, 1) == 0 ? 4'h8 : 4'h3, 26'($urandom), 2'b00};
    end
    if (!lsu_pend && ($urandom_range(0, 2) != 0)) begin
      lsu_pend = 1'b1;
      lsu_a = $urandom;
      lsu_s = 3'($urandom_range(0, 2));
    end
    ifu_arvalid = ifu_pend & !rst_now;
    lsu_arvalid = lsu_pend & !rst_now;
    ifu_araddr  = ifu_pend ? ifu_a : $urandom;
    lsu_araddr  = lsu_pend ? lsu_a : $urandom;
    lsu_arsize  = lsu_pend ? lsu_s : 3'($urandom);
    ifu_rready  = ($urandom_range(0, 9) < 7);
    lsu_rready  = ($urandom_range(0, 9) < 7);
    out_arready = ($urandom_range(0, 9) < 6);
    // Slave: returns addr^DEADBEEF after 0..2 cycles, occasionally glitches rvalid while idle
    if (sl_pend && sl_cnt == 0) begin
      out_rvalid = 1'b1;
      out_rdata  = sl_addr ^ 32'hDEAD_BEEF;
    end else if (sl_pend) begin
      sl_cnt--;
      out_rvalid = 1'b0;
      out_rdata  = $urandom;
    end else begin
      out_rvalid = ($urandom_range(0, 15) == 0) && !rst_now;
      out_rdata  = $urandom;
    end
  endtask

  initial begin
    bit pref_ifu;
    bit exp_ifu_rv, exp_lsu_rv, exp_rr;
    bit [31:0] exp_ifu_rd, exp_lsu_rd;

    reset = 1'b1; rst_now = 1'b0;
    ifu_araddr = 32'h0; lsu_araddr = 32'h0; lsu_arsize = 3'b0;
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
    out_arready = 1'b0; out_rvalid = 1'b0; out_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ar", {out_arvalid, out_araddr, out_arsize}, {1'b0, 32'h0, 3'b010});
    check_eq("reset_hs", {ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, out_rready}, 5'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_inputs();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Expected grant: LSU unless a tie and the IFU is owed its turn
`ifdef YSYX_ARB_RR_EN
      pref_ifu = m_last_lsu;
`else
      pref_ifu = 1'b0;
`endif
      g_lsu = !m_busy && lsu_arvalid && !(ifu_arvalid && pref_ifu);
      g_ifu = !m_busy && ifu_arvalid && !g_lsu;
      if (!m_busy && ifu_arvalid && lsu_arvalid) n_collide++;
      exp_ifu_rv = 1'b0; exp_lsu_rv = 1'b0; exp_rr = 1'b0;
      exp_ifu_rd = 32'h0; exp_lsu_rd = 32'h0;
      if (m_busy && m_data_phase) begin
        if (m_who_lsu) begin
          exp_lsu_rv = out_rvalid; exp_lsu_rd = out_rdata; exp_rr = lsu_rready;
        end else begin
          exp_ifu_rv = out_rvalid; exp_ifu_rd = out_rdata; exp_rr = ifu_rready;
        end
      end
      check_eq("arready", {ifu_arready, lsu_arready}, {g_ifu, g_lsu});
      check_eq("ar_chan", {out_arvalid, out_araddr, out_arsize},
               {m_busy && !m_data_phase, m_addr, m_size});
      check_eq("r_ctl", {ifu_rvalid, lsu_rvalid, out_rready}, {exp_ifu_rv, exp_lsu_rv, exp_rr});
      check_eq("ifu_rdata", ifu_rdata, exp_ifu_rd);
      check_eq("lsu_rdata", lsu_rdata, exp_lsu_rd);
      if (m_busy && m_data_phase && out_rvalid && exp_rr)
        check_eq("read_data", out_rdata, m_addr ^ 32'hDEAD_BEEF);

      // Model next state, computed from bench-owned inputs only
      if (g_ifu || g_lsu) begin
        m_busy = 1'b1; m_data_phase = 1'b0; m_who_lsu = g_lsu; m_last_lsu = g_lsu;
        m_addr = g_lsu ? lsu_a : ifu_a;
        m_size = g_lsu ? lsu_s : 3'b010;
        if (g_lsu) lsu_pend = 1'b0; else ifu_pend = 1'b0;
      end else if (m_busy && !m_data_phase && out_arready) begin
        m_data_phase = 1'b1;
      end else if (m_busy && m_data_phase && out_rvalid && exp_rr) begin
        m_busy = 1'b0;
      end
      s_arhs = out_arvalid && out_arready;
      s_rhs  = out_rvalid && out_rready;

      @(posedge clk); #1;
      if (rst_now) begin
        rst_now = 1'b0;
        reset   = 1'b0;
      end
      if (s_rhs) sl_pend = 1'b0;
      if (s_arhs) begin
        sl_pend = 1'b1;
        sl_addr = out_araddr;
        sl_cnt  = $urandom_range(0, 2);
      end
      if (m_busy && $urandom_range(0, 149) == 0) begin
        rst_now = 1'b1;
        reset   = 1'b1;
        model_reset();
      end
      drive_inputs();
    end

    check_eq("collisions_seen", 64'(n_collide > 20), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
